// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline-control encodings, FSM states and defaults.
package riscv_pipe_pkg;
  localparam int REG_AW_DEF = 5;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  typedef enum logic {RUN, MEM_WAIT} state_e;
endpackage

// File: rtl/riscv_sat_counter.sv
// riscv_sat_counter: up-counter that sticks at all-ones.
module riscv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign value = cnt_q;
endmodule

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: forwarding, load-use stall, branch flush and data-memory
// wait/timeout control for the 5-stage pipeline, plus stall/flush counters.
module riscv_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 12,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              mem_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              id_ex_hold,
  output logic              ex_mem_hold,
  output logic              id_ex_bubble,
  output logic              mem_wb_bubble,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              mem_abort,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              mem_stall, abort, flush, load_use, lu;
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    mem_stall = 1'b0;
    abort     = 1'b0;
    if (state_q == RUN) begin
      if (dmem_req && !dmem_ack) begin
        mem_stall = 1'b1;
        state_d   = MEM_WAIT;
        wcnt_d    = WAIT_W'(1);
      end
    end else if (dmem_ack) begin
      state_d = RUN;
      wcnt_d  = '0;
    end else if (wcnt_q == WAIT_W'(MEM_TIMEOUT)) begin
      abort   = 1'b1;
      err_d   = 1'b1;
      state_d = RUN;
      wcnt_d  = '0;
    end else begin
      mem_stall = 1'b1;
      wcnt_d    = wcnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  // Memory stall beats branch flush beats load-use; the flush squashes the ID load consumer.
  assign load_use = ex_mem_read && ex_rd != '0 &&
                    ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  assign flush = mem_branch_taken && state_q == RUN && !mem_stall;
  assign lu    = load_use && !mem_stall && !flush && !abort;
  always_comb begin
    fwd_a = rst ? FWD_RF
          : (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1) ? FWD_EXMEM
          : (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1)    ? FWD_MEMWB : FWD_RF;
    fwd_b = rst ? FWD_RF
          : (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2) ? FWD_EXMEM
          : (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2)    ? FWD_MEMWB : FWD_RF;
  end
  assign pc_hold       = !rst && (mem_stall || lu);
  assign if_id_hold    = pc_hold;
  assign id_ex_hold    = !rst && mem_stall;
  assign ex_mem_hold   = id_ex_hold;
  assign id_ex_bubble  = !rst && lu;
  assign mem_wb_bubble = !rst && (mem_stall || abort);
  assign flush_if_id   = !rst && flush;
  assign flush_id_ex   = flush_if_id;
  assign flush_ex_mem  = flush_if_id;
  assign mem_abort     = !rst && abort;
  assign err_timeout   = err_q;
  riscv_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(pc_hold), .value(stall_cnt)
  );
  riscv_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_if_id), .value(flush_cnt)
  );
endmodule
